// File: rtl/exe_muldiv_unit.sv
// Multi-cycle RV M-extension unit: multiplier with MUL_STAGES latency and a radix-2 restoring
// divider, one operation in flight, single-cycle tagged result pulse.
module exe_muldiv_unit #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            EXE_V,
  input  logic [2:0]      EXE_OP,
  input  logic [XLEN-1:0] EXE_ALU1,
  input  logic [XLEN-1:0] EXE_ALU2,
  input  logic [4:0]      EXE_DR,
  input  logic            FLUSH,
  output logic            MD_READY,
  output logic            MD_BUSY,
  output logic            MD_DONE,
  output logic [XLEN-1:0] MD_RES,
  output logic [4:0]      MD_DR
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;      // multiplicand, or dividend shifting into quotient
  logic [XLEN-1:0] b_q, b_d;      // multiplier, or divisor magnitude
  logic [XLEN-1:0] rem_q, rem_d;
  logic            quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;
  logic [4:0]      dr_q, dr_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [4:0]      md_dr_q, md_dr_d;

  logic              accept;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic [XLEN:0]     rem_sh, diff;
  logic              in_signed, s1, s2, in_zero, in_ovf;
  logic [XLEN-1:0]   min_int;

  assign MD_READY = (state_q == StIdle) || (state_q == StDone);
  assign MD_BUSY  = (state_q == StMul) || (state_q == StDiv);
  assign MD_DONE  = (state_q == StDone);
  assign MD_RES   = res_q;
  assign MD_DR    = md_dr_q;

  assign accept = EXE_V && MD_READY && !FLUSH;

  // Operands are extended to 2*XLEN so one truncated multiply covers all four signedness cases
  always_comb begin
    mul_a = {{XLEN{(op_q == 2'd1 || op_q == 2'd2) && a_q[XLEN-1]}}, a_q};
    mul_b = {{XLEN{(op_q == 2'd1) && b_q[XLEN-1]}}, b_q};
    prod  = mul_a * mul_b;
  end

  assign rem_sh = {rem_q, a_q[XLEN-1]};
  assign diff   = rem_sh - {1'b0, b_q};

  assign min_int   = {1'b1, {(XLEN-1){1'b0}}};
  assign in_signed = !EXE_OP[0];
  assign s1        = in_signed && EXE_ALU1[XLEN-1];
  assign s2        = in_signed && EXE_ALU2[XLEN-1];
  assign in_zero   = (EXE_ALU2 == '0);
  assign in_ovf    = in_signed && (EXE_ALU1 == min_int) && (&EXE_ALU2);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    dr_d      = dr_q;
    res_d     = res_q;
    md_dr_d   = md_dr_q;

    unique case (state_q)
      StMul: begin
        if (cnt_q == CW'(MUL_STAGES - 1)) begin
          state_d = StDone;
          res_d   = (op_q == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          md_dr_d = dr_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDiv: begin
        if (cnt_q != CW'(XLEN)) begin
          rem_d = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
          a_d   = {a_q[XLEN-2:0], ~diff[XLEN]};
          cnt_d = cnt_q + CW'(1);
        end else begin
          // Sign fixup edge; special cases arrive here with flags cleared
          state_d = StDone;
          if (op_q[1]) res_d = rem_neg_q ? -rem_q : rem_q;
          else         res_d = quo_neg_q ? -a_q : a_q;
          md_dr_d = dr_q;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (accept) begin
      op_d  = EXE_OP[1:0];
      dr_d  = EXE_DR;
      cnt_d = '0;
      if (EXE_OP[2]) begin
        state_d   = StDiv;
        a_d       = s1 ? -EXE_ALU1 : EXE_ALU1;
        b_d       = s2 ? -EXE_ALU2 : EXE_ALU2;
        rem_d     = '0;
        quo_neg_d = s1 ^ s2;
        rem_neg_d = s1;
        // Special cases skip the iterations and land on the fixup edge with final values
        if (in_zero || in_ovf) begin
          cnt_d     = CW'(XLEN);
          quo_neg_d = 1'b0;
          rem_neg_d = 1'b0;
          a_d       = in_zero ? '1 : EXE_ALU1;
          rem_d     = in_zero ? EXE_ALU1 : '0;
        end
      end else begin
        state_d = StMul;
        a_d     = EXE_ALU1;
        b_d     = EXE_ALU2;
      end
    end

    if (FLUSH) begin
      state_d = StIdle;
      res_d   = res_q;
      md_dr_d = md_dr_q;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dr_q      <= '0;
      res_q     <= '0;
      md_dr_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      dr_q      <= dr_d;
      res_q     <= res_d;
      md_dr_q   <= md_dr_d;
    end
  end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed and randomised checks of exe_muldiv_unit (XLEN=64, MUL_STAGES=2) against a
// queue of expected results, latencies and tags.
module tb_exe_muldiv_unit;

  localparam int unsigned XLEN = 64;

  logic            CLK = 1'b0;
  logic            RESET_N;
  logic            EXE_V = 1'b0;
  logic [2:0]      EXE_OP = '0;
  logic [XLEN-1:0] EXE_ALU1 = '0;
  logic [XLEN-1:0] EXE_ALU2 = '0;
  logic [4:0]      EXE_DR = '0;
  logic            FLUSH = 1'b0;
  logic            MD_READY, MD_BUSY, MD_DONE;
  logic [XLEN-1:0] MD_RES;
  logic [4:0]      MD_DR;

  exe_muldiv_unit #(.XLEN(64), .MUL_STAGES(2)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .EXE_V(EXE_V), .EXE_OP(EXE_OP), .EXE_ALU1(EXE_ALU1),
    .EXE_ALU2(EXE_ALU2), .EXE_DR(EXE_DR), .FLUSH(FLUSH), .MD_READY(MD_READY),
    .MD_BUSY(MD_BUSY), .MD_DONE(MD_DONE), .MD_RES(MD_RES), .MD_DR(MD_DR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  dr;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  localparam logic [63:0] MinInt = 64'h8000_0000_0000_0000;
  localparam logic [63:0] Ones   = 64'hFFFF_FFFF_FFFF_FFFF;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
    logic signed [127:0] x, y;
    logic [127:0] p;
    case (op)
      3'd0, 3'd3: begin x = {64'd0, a}; y = {64'd0, b}; end
      3'd1:       begin x = $signed(a); y = $signed(b); end
      default:    begin x = $signed(a); y = {64'd0, b}; end
    endcase
    p = x * y;
    case (op)
      3'd0:    return p[63:0];
      3'd1, 3'd2, 3'd3: return p[127:64];
      3'd4:    return (b == 0) ? Ones : (a == MinInt && b == Ones) ? a
                                      : 64'($signed(a) / $signed(b));
      3'd5:    return (b == 0) ? Ones : a / b;
      3'd6:    return (b == 0) ? a : (a == MinInt && b == Ones) ? 64'd0
                                   : 64'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    if (!op[2]) return 2;
    if (b == 0 || (!op[0] && a == MinInt && b == Ones)) return 1;
    return 65;
  endfunction

  // Called right after a falling edge; the request is accepted at the next rising edge
  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] dr, input logic [63:0] exp, input bit track);
    EXE_V = 1'b1; EXE_OP = op; EXE_ALU1 = a; EXE_ALU2 = b; EXE_DR = dr;
    if (track) q.push_back('{exp, dr, cyc + 1 + lat(op, a, b)});
    @(negedge CLK);
    EXE_V = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, 64'(q.size()), 64'd0);
    @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    if (RESET_N === 1'b1 && MD_DONE === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_done", 64'(MD_DONE), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", MD_RES, e.res);
        chk("tag", 64'(MD_DR), 64'(e.dr));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rop;
    logic [63:0] ra, rb;

    RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_ready", 64'(MD_READY), 64'd1);
    chk("rst_busy", 64'(MD_BUSY), 64'd0);
    chk("rst_done", 64'(MD_DONE), 64'd0);
    chk("rst_res", MD_RES, 64'd0);
    chk("rst_dr", 64'(MD_DR), 64'd0);
    RESET_N = 1'b1;
    @(negedge CLK);

    // Multiplies: signedness of the high half
    issue(3'd1, Ones, 64'd2, 5'd1, Ones, 1'b1);
    drain("mulh_drain", 20);
    issue(3'd3, Ones, 64'd2, 5'd2, 64'd1, 1'b1);
    drain("mulhu_drain", 20);
    issue(3'd0, Ones, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    drain("mul_drain", 20);
    issue(3'd2, 64'hFFFF_FFFF_FFFF_FFFD, MinInt, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    drain("mulhsu_drain", 20);
    issue(3'd1, 64'hFFFF_FFFF_FFFF_FFFD, MinInt, 5'd5, 64'd1, 1'b1);
    drain("mulh2_drain", 20);
    issue(3'd3, 64'hFFFF_FFFF_FFFF_FFFD, MinInt, 5'd6, 64'h7FFF_FFFF_FFFF_FFFE, 1'b1);
    drain("mulhu2_drain", 20);

    // Divides
    issue(3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
    repeat (5) @(negedge CLK);
    chk("div_busy", 64'(MD_BUSY), 64'd1);
    chk("div_not_ready", 64'(MD_READY), 64'd0);
    drain("div_drain", 100);
    issue(3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd8, Ones, 1'b1);
    drain("rem_drain", 100);
    issue(3'd5, 64'd100, 64'd7, 5'd9, 64'd14, 1'b1);
    drain("divu_drain", 100);
    issue(3'd7, 64'd100, 64'd7, 5'd10, 64'd2, 1'b1);
    drain("remu_drain", 100);

    // Divide by zero and signed overflow
    issue(3'd5, 64'd5, 64'd0, 5'd11, Ones, 1'b1);
    drain("divu0_drain", 10);
    issue(3'd6, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd12, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1);
    drain("rem0_drain", 10);
    issue(3'd4, MinInt, Ones, 5'd13, MinInt, 1'b1);
    drain("divovf_drain", 10);
    issue(3'd6, MinInt, Ones, 5'd14, 64'd0, 1'b1);
    drain("removf_drain", 10);

    // Flush mid-divide, then a multiply
    issue(3'd4, 64'd1000, 64'd3, 5'd15, 64'd0, 1'b0);
    repeat (9) @(negedge CLK);
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    chk("flush_ready", 64'(MD_READY), 64'd1);
    chk("flush_busy", 64'(MD_BUSY), 64'd0);
    issue(3'd0, 64'd3, 64'd4, 5'd16, 64'd12, 1'b1);
    drain("flush_mul_drain", 80);

    // Request with FLUSH in idle is dropped
    FLUSH = 1'b1;
    issue(3'd0, 64'd7, 64'd7, 5'd17, 64'd0, 1'b0);
    FLUSH = 1'b0;
    chk("flush_drop_busy", 64'(MD_BUSY), 64'd0);
    repeat (4) @(negedge CLK);

    // Back-to-back: multiply accepted in the divide's done cycle
    issue(3'd5, 64'd100, 64'd7, 5'd18, 64'd14, 1'b1);
    begin
      int n = 0;
      while (MD_DONE !== 1'b1 && n < 100) begin
        @(negedge CLK);
        n++;
      end
      chk("b2b_wait", 64'(MD_DONE), 64'd1);
    end
    chk("b2b_ready", 64'(MD_READY), 64'd1);
    issue(3'd0, 64'd5, 64'd6, 5'd19, 64'd30, 1'b1);
    drain("b2b_drain", 20);

    // Randomised mix against the arithmetic model
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = {$urandom, $urandom};
      rb  = (i % 3 == 0) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom};
      issue(rop, ra, rb, 5'(20 + i), model(rop, ra, rb), 1'b1);
      drain("rand_drain", 100);
    end

    // Reset mid-multiply aborts without a result
    issue(3'd0, 64'd9, 64'd9, 5'd30, 64'd0, 1'b0);
    RESET_N = 1'b0;
    #1;
    chk("rstmid_done", 64'(MD_DONE), 64'd0);
    chk("rstmid_busy", 64'(MD_BUSY), 64'd0);
    chk("rstmid_ready", 64'(MD_READY), 64'd1);
    chk("rstmid_res", MD_RES, 64'd0);
    chk("rstmid_dr", 64'(MD_DR), 64'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (4) @(negedge CLK);
    chk("rstmid_idle_done", 64'(MD_DONE), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
